// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch port and the load/store port.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed LS-over-IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic {
        PORT_IF,
        PORT_LS
    } port_e;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..7");
    end

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    state_e            state, state_n;
    port_e             grant, grant_n;
    port_e             pick;
    logic [2:0]        cnt, cnt_n;
    logic              mem_en_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [DATA_W-1:0] if_rdata_n, ls_rdata_n;
    logic              if_ack_n, ls_ack_n;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_e             last_grant, last_grant_n;
`endif

    // Winner if a grant happens this cycle; only consulted in IDLE with a request present.
    always_comb begin
        pick = PORT_IF;
        if (ls_req && if_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick = (last_grant == PORT_IF) ? PORT_LS : PORT_IF;
`else
            pick = PORT_LS;
`endif
        end else if (ls_req) begin
            pick = PORT_LS;
        end
    end

    // Every output is computed one cycle ahead here and registered below,
    // so the registered view lines up with the FSM state it belongs to.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first; any
        // path that skipped an assignment would otherwise infer a latch.
        state_n     = state;
        grant_n     = grant;
        cnt_n       = cnt;
        mem_en_n    = 1'b0;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        ls_rdata_n  = ls_rdata;
        if_ack_n    = 1'b0;
        ls_ack_n    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_n = last_grant;
`endif

        unique case (state)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    state_n  = S_ISSUE;
                    grant_n  = pick;
                    mem_en_n = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_n = pick;
`endif
                    if (pick == PORT_LS) begin
                        mem_we_n    = ls_we;
                        mem_addr_n  = ls_addr;
                        mem_wdata_n = ls_wdata;
                    end else begin
                        mem_we_n    = 1'b0;
                        mem_addr_n  = if_addr;
                        mem_wdata_n = '0;
                    end
                end
            end

            S_ISSUE: begin
                if (mem_we) begin
                    state_n  = S_DONE;
                    ls_ack_n = 1'b1;
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = LAT_LOAD;
                end
            end

            S_WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_n = cnt - 3'd1;
                end else begin
                    state_n = S_DONE;
                    if (grant == PORT_LS) begin
                        ls_rdata_n = mem_rdata;
                        ls_ack_n   = 1'b1;
                    end else begin
                        if_rdata_n = mem_rdata;
                        if_ack_n   = 1'b1;
                    end
                end
            end

            S_DONE: begin
                // Requests are deliberately not sampled here; the requester drops req this cycle.
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= PORT_IF;
            cnt       <= 3'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            cnt       <= cnt_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            ls_rdata  <= ls_rdata_n;
            if_ack    <= if_ack_n;
            ls_ack    <= ls_ack_n;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Resets to IF so the first contested grant goes to LS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_IF;
        end else begin
            last_grant <= last_grant_n;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port memory between the instruction-fetch port (read-only) and the load/store port of the RISC-V core, for multi-cycle or unified-memory builds.
- Sequences each access through a small FSM: arbitrate, issue, wait for a fixed memory latency, return data.
- Returns data with a one-cycle acknowledge pulse.
- Sits between the program counter / instruction path, the ALU address output and the memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata. Legal range 1..7; 0 is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched instruction; valid with if_ack.
- if_ack  out  1  one-cycle completion pulse.
- ls_req  in  1  load/store request; held until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_rdata  out  DATA_W  load data; valid with ls_ack.
- ls_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; only meaningful when mem_en=1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values (asynchronous, effective immediately on rst):
  - state = IDLE; all outputs = 0 (including if_rdata and ls_rdata).
  - 3-bit latency counter = 0; last_grant = IF.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: samples if_req and ls_req.
    - Neither asserted → stay in IDLE.
    - Otherwise grant one port, latch its addr/we/wdata into the mem_* registers, and go to ISSUE. For the IF port, mem_we = 0 and mem_wdata = 0.
    - Both asserted → LS wins (fixed priority; see Optional Feature).
  - ISSUE: mem_en = 1 for exactly this cycle.
    - Store → DONE.
    - Load or fetch → WAIT, with counter loaded to MEM_LATENCY-1.
  - WAIT: mem_en = 0.
    - While counter > 0: decrement.
    - When counter = 0: register mem_rdata into the granted port's rdata and go to DONE.
  - DONE: granted port's ack = 1 for this cycle only, then → IDLE. Requests are not sampled in DONE, which guarantees the requester has dropped req before the next arbitration.
- Latency, with request seen in IDLE at cycle 0:
  - mem_en asserted in cycle 1.
  - Read ack in cycle 2+MEM_LATENCY.
  - Write ack in cycle 2.
  - Back-to-back transactions start every 3+MEM_LATENCY cycles for reads and every 3 cycles for writes.
- The rdata of a port holds its last value until that port's next read completes. A write never changes ls_rdata.
- Requester deasserts req mid-transaction: the transaction completes and the ack is still pulsed. The bench flags this as a protocol error.
- ls_we, ls_addr and ls_wdata are ignored unless LS is granted.
- rst asserted mid-transaction: the transaction is aborted, no ack is ever issued for it, and mem_en drops immediately.
- The ungranted port's ack stays 0 for the whole transaction.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the port not equal to last_grant. last_grant updates on every grant. Because last_grant resets to IF, the first contested grant goes to LS.
- Undefined: fixed priority, LS over IF. last_grant register is omitted.

Test Plan:
1. Reset: pulse rst=1 between clock edges mid-transaction → all outputs 0 without waiting for a clock edge, and no ack afterwards.
2. Fetch, MEM_LATENCY=1: if_addr=0x00000010, memory returns 0x00500093 → mem_en=1, mem_we=0, mem_addr=0x10 in cycle 1; if_ack=1 and if_rdata=0x00500093 in cycle 3; ls_ack stays 0.
3. Store: ls_we=1, ls_addr=0x20, ls_wdata=0xDEADBEEF → cycle 1 shows mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; ls_ack in cycle 2; ls_rdata unchanged.
4. Contention, macro off, MEM_LATENCY=1, both reads raised in cycle 0 → LS mem_en in cycle 1, ls_ack in cycle 3; IF mem_en in cycle 5, if_ack in cycle 7.
5. Macro on, both reqs re-raised immediately after every ack for 4 transactions → grant order LS, IF, LS, IF. Macro off, same stimulus → LS, LS, LS, LS.
6. MEM_LATENCY=3 load at 0x40 → mem_en in cycle 1, ls_ack in cycle 5 with the data sampled in cycle 4. Repeat with rst asserted in cycle 3 → no ls_ack, and FSM in IDLE after rst deasserts.
